// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared core-wide defines: widths, zero word, enable levels
package regfile_pkg;

  // Datapath and register-address widths shared across the pipeline.
  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;
  localparam int RegNum     = 32;

  localparam logic [RegLen-1:0] ZERO_WORD = '0;

  // Active levels for the pipeline control strobes.
  localparam logic ResetEnable  = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - priority mux for one register-file read port
//
// Ports:
//   rst        reset level; forces the read data to zero
//   re         read enable for this port
//   raddr      read address for this port
//   we         write enable of the write-back port
//   waddr      write-back destination register
//   wdata      write-back data (bypass source)
//   store_data storage content at raddr
//   rdata      resolved read data (combinational)
module regfile_rd_port #(
  parameter int RegLen     = regfile_pkg::RegLen,
  parameter int RegAddrLen = regfile_pkg::RegAddrLen
) (
  input  logic                  rst,
  input  logic                  re,
  input  logic [RegAddrLen-1:0] raddr,
  input  logic                  we,
  input  logic [RegAddrLen-1:0] waddr,
  input  logic [RegLen-1:0]     wdata,
  input  logic [RegLen-1:0]     store_data,
  output logic [RegLen-1:0]     rdata
);

  import regfile_pkg::*;

  localparam logic [RegLen-1:0] Zero = RegLen'(ZERO_WORD);

  // The x0 check sits above the bypass so a dropped write to x0 can never
  // leak its data onto a read of x0.
  always_comb begin
    rdata = Zero;
    if (rst == ResetEnable) begin
      rdata = Zero;
    end else if (re == ReadDisable) begin
      rdata = Zero;
    end else if (raddr == '0) begin
      rdata = Zero;
    end else if ((we == WriteEnable) && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      rdata = store_data;
    end
  end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - RV32I architectural register file, 1 write / 2 read ports
//
// Ports:
//   clk     clock
//   rst     synchronous active-high reset; clears every entry
//   we      write enable from WB
//   waddr   write destination register
//   wdata   write data
//   re1     read enable, port 1 (rs1)
//   raddr1  read address, port 1
//   rdata1  read data, port 1 (combinational, with WB bypass)
//   re2     read enable, port 2 (rs2)
//   raddr2  read address, port 2
//   rdata2  read data, port 2 (combinational, with WB bypass)
module regfile #(
  parameter int RegLen     = regfile_pkg::RegLen,
  parameter int RegAddrLen = regfile_pkg::RegAddrLen,
  parameter int RegNum     = regfile_pkg::RegNum
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrLen-1:0] waddr,
  input  logic [RegLen-1:0]     wdata,
  input  logic                  re1,
  input  logic [RegAddrLen-1:0] raddr1,
  output logic [RegLen-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrLen-1:0] raddr2,
  output logic [RegLen-1:0]     rdata2
);

  import regfile_pkg::*;

  logic [RegLen-1:0] regs [RegNum];

  // Entry 0 is only ever written by reset, so it holds zero permanently.
  // Reset takes priority, discarding any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      for (int i = 0; i < RegNum; i++) begin
        regs[i] <= '0;
      end
    end else if ((we == WriteEnable) && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  regfile_rd_port #(
    .RegLen     (RegLen),
    .RegAddrLen (RegAddrLen)
  ) u_rd_port1 (
    .rst        (rst),
    .re         (re1),
    .raddr      (raddr1),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .store_data (regs[raddr1]),
    .rdata      (rdata1)
  );

  regfile_rd_port #(
    .RegLen     (RegLen),
    .RegAddrLen (RegAddrLen)
  ) u_rd_port2 (
    .rst        (rst),
    .re         (re2),
    .raddr      (raddr2),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .store_data (regs[raddr2]),
    .rdata      (rdata2)
  );

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int total = 0;
  int bad   = 0;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Inputs change just after a negedge; checks run mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_wr();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; idle_wr();
    re1 = 1'b1; raddr1 = 5'd5;
    re2 = 1'b1; raddr2 = 5'd31;
    @(negedge clk);
    settle();
    chk("rst_hold_rd1", rdata1, 32'h0);
    chk("rst_hold_rd2", rdata2, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_x5", rdata1, 32'h0);
    chk("post_rst_x31", rdata2, 32'h0);

    // Preload x5 and confirm through storage.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle_wr();
    settle();
    chk("preload_x5", rdata1, 32'hDEADBEEF);

    // Reset clears x5; outputs are zero while reset is held.
    rst = 1'b1;
    settle();
    chk("rst_forces_zero", rdata1, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_clear_x5", rdata1, 32'h0);

    // Basic write then read via port 2; port 1 disabled.
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
    tick();
    idle_wr();
    re1 = 1'b0; raddr1 = 5'd3;
    re2 = 1'b1; raddr2 = 5'd3;
    settle();
    chk("basic_rd2_x3", rdata2, 32'h12345678);
    chk("basic_re1_off", rdata1, 32'h0);

    // Bypass on both ports in the same cycle.
    re1 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'hCAFEF00D;
    settle();
    chk("bypass_rd1", rdata1, 32'hCAFEF00D);
    chk("bypass_rd2", rdata2, 32'hCAFEF00D);
    tick();
    idle_wr();
    settle();
    chk("bypass_stored_rd1", rdata1, 32'hCAFEF00D);
    chk("bypass_stored_rd2", rdata2, 32'hCAFEF00D);

    // Write to a different register must not bypass onto x7 / x3 reads.
    we = 1'b1; waddr = 5'd10; wdata = 32'h0BADF00D;
    raddr2 = 5'd3;
    settle();
    chk("no_bypass_mismatch1", rdata1, 32'hCAFEF00D);
    chk("no_bypass_mismatch2", rdata2, 32'h12345678);
    tick();
    idle_wr();
    raddr1 = 5'd10;
    settle();
    chk("x10_stored", rdata1, 32'h0BADF00D);

    // x0 immunity, including the bypass path.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    settle();
    chk("x0_same_cycle_rd1", rdata1, 32'h0);
    chk("x0_same_cycle_rd2", rdata2, 32'h0);
    tick();
    idle_wr();
    settle();
    chk("x0_next_cycle", rdata1, 32'h0);
    tick();
    settle();
    chk("x0_later_cycle", rdata2, 32'h0);

    // Reset beats a concurrent write; bypass is also suppressed under reset.
    rst = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000001;
    raddr1 = 5'd9; raddr2 = 5'd9;
    settle();
    chk("rst_blocks_bypass", rdata2, 32'h0);
    tick();
    rst = 1'b0;
    idle_wr();
    settle();
    chk("rst_beats_write_x9", rdata1, 32'h0);
    raddr2 = 5'd7;
    settle();
    chk("rst_cleared_x7", rdata2, 32'h0);

    // Last write wins on consecutive edges.
    raddr1 = 5'd4; raddr2 = 5'd4;
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000000A;
    settle();
    chk("lww_first_bypass", rdata1, 32'h0000000A);
    tick();
    wdata = 32'h0000000B;
    settle();
    chk("lww_second_bypass", rdata1, 32'h0000000B);
    tick();
    idle_wr();
    settle();
    chk("lww_final_rd1", rdata1, 32'h0000000B);
    chk("lww_final_rd2", rdata2, 32'h0000000B);

    // Port independence: port 2 disabled while port 1 reads.
    re2 = 1'b0;
    settle();
    chk("indep_rd1", rdata1, 32'h0000000B);
    chk("indep_rd2_off", rdata2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
